serial_sum_deserializer: RTL and testbench
==========================================

# serial_sum_deserializer

Downstream stage of the serial adder: it consumes the LSB-first `Sum` bit stream and final `Cy` bit, reassembles them into a parallel `WIDTH+1`-bit result, and offers that result on a valid/ready handshake. A one-entry output register decouples collection of the next frame from consumer back-pressure. Framing errors and overruns are reported as sticky flags.

## Interface
- `WIDTH`, default 4: operand width, i.e. number of sum bits per frame; legal range 1..32.
- `clk`  in  1: single clock; all sampling on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `sum_in`  in  1: serial sum bit from the adder, LSB first.
- `cy_in`  in  1: adder carry; sampled only with the last bit of a frame.
- `bit_valid`  in  1: `sum_in` is valid this cycle.
- `frame_start`  in  1: qualified by `bit_valid`; marks the current bit as bit 0 (LSB) of a new frame.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `err_clr`  in  1: clears `overrun` and `frame_err`.
- `out_data`  out  WIDTH+1: `{carry, sum[WIDTH-1:0]}`.
- `out_valid`  out  1: `out_data` holds an unconsumed result.
- `busy`  out  1: a frame is partially collected.
- `overrun`  out  1: sticky; a completed frame was dropped.
- `frame_err`  out  1: sticky; a frame was aborted by an early `frame_start`.

## Operation
- Reset: all outputs are 0; state IDLE; shift register and bit counter are 0.
- FSM states are IDLE and SHIFT. `busy` = (state == SHIFT).
- IDLE:
  - `bit_valid & frame_start`: capture `sum_in` as bit 0 and set count = 1. Go to SHIFT, or complete immediately if WIDTH == 1.
  - `bit_valid` without `frame_start`: ignore the bit.
- SHIFT, `bit_valid` high:
  - Shift `sum_in` in at position `count` (LSB-first fill) and increment `count`.
  - When `count` reaches WIDTH, the frame completes: result = `{cy_in, shreg}` using this cycle's `cy_in`. Return to IDLE.
- SHIFT, `bit_valid` low: hold all state (stall). There is no timeout.
- `frame_start` with `bit_valid` in SHIFT: abort the partial frame, set `frame_err`, and restart with this bit as bit 0 (count = 1).
- Completion with the output register free, or with `out_valid & out_ready` in the same cycle: load `out_data` and set `out_valid`.
- Completion while `out_valid & ~out_ready`: drop the new result, keep the old `out_data`, set `overrun`.
- Handshake:
  - A transfer occurs on an edge where `out_valid & out_ready`; `out_valid` then clears unless a completion loads a new result on the same edge.
  - `out_data` is stable while `out_valid & ~out_ready`.
- `err_clr`: clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- `rst` asserted mid-frame or with a held result: everything returns to reset values asynchronously. The partial frame and any held result are lost, with no flag.

## Timing
- Latency: `out_valid` rises at the edge that samples the last bit, so it is visible one cycle after the last bit is presented.
- Throughput: one frame per WIDTH cycles. Back-to-back frames are supported, with `frame_start` on the cycle right after a frame's last bit.
- With a consumer holding `out_ready` high, back-to-back frames produce no bubbles and no overrun.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `serial_pkg` holds:
  - `SA_WIDTH` = 4;
  - the state enum `des_state_t` {IDLE, SHIFT};
  - a `sa_result_t` typedef for the `WIDTH+1` packed result.
- Counter width is `$clog2(WIDTH+1)`.
- One natural sub-module is `sipo_shreg`: a WIDTH-bit serial-in parallel-out register with load-at-bit-0, shift-enable and clear. The FSM, output register and flags stay in the top module.

## Test plan
- Single frame: `frame_start` with sum bits 1,0,0,1 (LSB first), `cy_in` = 1 on the 4th bit, `out_ready` = 1 → `out_valid` for exactly one cycle with `out_data` = 5'b11001.
- Stall: the same frame with `bit_valid` low for 3 cycles between bits 2 and 3 → identical `out_data`, and `busy` held through the gap.
- Back-pressure / overrun:
  - First frame gives `out_data` = 5'b01010 with `out_ready` = 0.
  - A second frame completes → `overrun` = 1 and `out_data` still 5'b01010.
  - `err_clr` → `overrun` = 0.
- Simultaneous: the second frame completes on the same edge that `out_ready` accepts the first → `out_valid` stays 1, `out_data` becomes the second result, and `overrun` stays 0.
- Early `frame_start` after 2 bits → `frame_err` = 1. The new frame 0,1,1,0 with `cy_in` = 0 → `out_data` = 5'b00110.
- `rst` pulse after 3 bits of a frame, and again while `out_valid` = 1 → all outputs 0 immediately, and the next full frame is collected correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types for the serial adder datapath.
// Used by the sum deserializer and its shift register.
package serial_pkg;

    localparam int SA_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } des_state_t;

    typedef logic [SA_WIDTH:0] sa_result_t;

endpackage

// File: rtl/serial_sum_deserializer_sipo_shreg.sv
// Serial-in parallel-out register, LSB-first positional fill.
// o_next exposes the value being written so a frame can complete on its last bit.
module sipo_shreg #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load0,
    input  logic             i_shift,
    input  logic [CW-1:0]    i_pos,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        if (i_clr) begin
            w_next = '0;
        end
        if (i_load0) begin
            // Load clears stale bits so an aborted frame leaves no residue.
            w_next    = '0;
            w_next[0] = i_bit;
        end else if (i_shift) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i_pos == CW'(i)) begin
                    w_next[i] = i_bit;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q    = r_q;
    assign o_next = w_next;

endmodule

// File: rtl/serial_sum_deserializer.sv
// Reassembles the LSB-first serial sum and final carry into a parallel
// result held in a one-entry valid/ready output register.
module serial_sum_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sum_in,
    input  logic           cy_in,
    input  logic           bit_valid,
    input  logic           frame_start,
    input  logic           out_ready,
    input  logic           err_clr,
    output logic [WIDTH:0] out_data,
    output logic           out_valid,
    output logic           busy,
    output logic           overrun,
    output logic           frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    des_state_t       r_state;
    des_state_t       w_state_nx;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nx;
    logic [WIDTH:0]   r_data;
    logic             r_valid;
    logic             r_ovr;
    logic             r_ferr;

    logic             w_start;
    logic             w_load0;
    logic             w_shift;
    logic             w_done;
    logic             w_abort;
    logic             w_free;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sh_q;
    logic [WIDTH-1:0] w_sh_next;
    logic [WIDTH:0]   w_result;

    assign w_start = bit_valid & frame_start;

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_load0    = 1'b0;
        w_shift    = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_load0    = 1'b1;
                    w_count_nx = CW'(1);
                    w_state_nx = SHIFT;
                    if (WIDTH == 1) begin
                        w_done     = 1'b1;
                        w_count_nx = '0;
                        w_state_nx = IDLE;
                    end
                end
            end
            SHIFT: begin
                if (w_start) begin
                    w_abort    = 1'b1;
                    w_load0    = 1'b1;
                    w_count_nx = CW'(1);
                end else if (bit_valid) begin
                    w_shift    = 1'b1;
                    w_count_nx = r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        w_done     = 1'b1;
                        w_count_nx = '0;
                        w_state_nx = IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_count_nx = '0;
            end
        endcase
    end

    sipo_shreg #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_load0 (w_load0),
        .i_shift (w_shift),
        .i_pos   (r_count),
        .i_bit   (sum_in),
        .o_q     (w_sh_q),
        .o_next  (w_sh_next)
    );

    assign w_result = {cy_in, w_sh_next};
    assign w_xfer   = r_valid & out_ready;
    assign w_free   = ~r_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
        end
    end

    // A completion may refill the register on the same edge it is drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_done & w_free) begin
            r_data  <= w_result;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_done & ~w_free) begin
                r_ovr <= 1'b1;
            end else if (err_clr) begin
                r_ovr <= 1'b0;
            end
            if (w_abort) begin
                r_ferr <= 1'b1;
            end else if (err_clr) begin
                r_ferr <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = (r_state == SHIFT);
    assign overrun   = r_ovr;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Directed and randomized bench for serial_sum_deserializer, compared
// against a frame-level reference model built from bit queues.
module tb_serial_sum_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sum_in = 1'b0;
    logic         cy_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         out_ready = 1'b0;
    logic         err_clr = 1'b0;
    logic [W:0]   out_data;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    int checks = 0;
    int failures = 0;

    bit         m_q[$];
    bit         m_busy;
    logic [W:0] m_data;
    bit         m_valid;
    bit         m_ovr;
    bit         m_ferr;

    serial_sum_deserializer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sum_in      (sum_in),
        .cy_in       (cy_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .out_ready   (out_ready),
        .err_clr     (err_clr),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy  = 0;
        m_data  = '0;
        m_valid = 0;
        m_ovr   = 0;
        m_ferr  = 0;
    endtask

    task automatic model_edge(input bit bv, s, cy, fs, rdy, clr);
        bit  done;
        bit  ovr_set;
        bit  ferr_set;
        int  res;
        done     = 0;
        ferr_set = 0;
        res      = 0;
        if (bv) begin
            if (fs) begin
                ferr_set = m_busy;
                m_q.delete();
                m_q.push_back(s);
                m_busy = 1;
            end else if (m_busy) begin
                m_q.push_back(s);
            end
            if (m_busy && m_q.size() == W) begin
                done = 1;
                res  = int'(cy) * (1 << W);
                foreach (m_q[i]) res += int'(m_q[i]) * (1 << i);
                m_busy = 0;
                m_q.delete();
            end
        end
        ovr_set = done && m_valid && !rdy;
        if (done && !ovr_set) begin
            m_data  = res[W:0];
            m_valid = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ovr  = ovr_set  | (m_ovr  & ~clr);
        m_ferr = ferr_set | (m_ferr & ~clr);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".data"}, 32'(out_data), 32'(m_data));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
        chk({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
    endtask

    task automatic step(input bit bv, s, cy, fs, rdy, clr, input string tag);
        bit_valid   = bv;
        sum_in      = s;
        cy_in       = cy;
        frame_start = fs;
        out_ready   = rdy;
        err_clr     = clr;
        @(posedge clk);
        model_edge(bv, s, cy, fs, rdy, clr);
        #1;
        check_all(tag);
    endtask

    task automatic send(input logic [W-1:0] sm, input bit cy,
                        input bit rdy, input bit rdy_last, input string tag);
        for (int i = 0; i < W; i++) begin
            step(1, sm[i], (i == W - 1) ? cy : 1'b0, i == 0,
                 (i == W - 1) ? rdy_last : rdy, 0, tag);
        end
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".zero"}, 32'({out_valid, busy, overrun, frame_err}), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, "idle");

        // Single frame 1,0,0,1 with carry.
        send(4'b1001, 1, 1, 1, "single");
        chk("single_data", 32'(out_data), 32'h19);
        chk("single_valid", 32'(out_valid), 1);
        step(0, 0, 0, 0, 1, 0, "single_drain");
        chk("single_onecycle", 32'(out_valid), 0);

        // Stall between bits 2 and 3.
        step(1, 1, 0, 1, 1, 0, "stall");
        step(1, 0, 0, 0, 1, 0, "stall");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 1, 0, "stall_gap");
            chk("stall_busy", 32'(busy), 1);
        end
        step(1, 0, 0, 0, 1, 0, "stall");
        step(1, 1, 1, 0, 1, 0, "stall");
        chk("stall_data", 32'(out_data), 32'h19);
        step(0, 0, 0, 0, 1, 0, "stall_drain");

        // Back-pressure and overrun.
        send(4'b1010, 0, 0, 0, "bp1");
        chk("bp1_data", 32'(out_data), 32'h0A);
        send(4'b0111, 1, 0, 0, "bp2");
        chk("bp2_ovr", 32'(overrun), 1);
        chk("bp2_data", 32'(out_data), 32'h0A);
        step(0, 0, 0, 0, 0, 1, "bp_clr");
        chk("bp_clr_ovr", 32'(overrun), 0);
        step(0, 0, 0, 0, 1, 0, "bp_drain");

        // Completion on the same edge the held result is accepted.
        send(4'b0011, 0, 0, 0, "sim1");
        send(4'b1100, 1, 0, 1, "sim2");
        chk("sim_valid", 32'(out_valid), 1);
        chk("sim_data", 32'(out_data), 32'h1C);
        chk("sim_ovr", 32'(overrun), 0);
        step(0, 0, 0, 0, 1, 0, "sim_drain");

        // Early frame_start aborts a partial frame.
        step(1, 1, 0, 1, 1, 0, "early");
        step(1, 1, 0, 0, 1, 0, "early");
        send(4'b0110, 0, 1, 1, "early_new");
        chk("early_ferr", 32'(frame_err), 1);
        chk("early_data", 32'(out_data), 32'h06);
        step(0, 0, 0, 0, 1, 1, "early_clr");
        chk("early_clr_ferr", 32'(frame_err), 0);

        // Reset mid-frame and with a held result.
        step(1, 1, 0, 1, 0, 0, "rst_mid");
        step(1, 1, 0, 0, 0, 0, "rst_mid");
        step(1, 1, 0, 0, 0, 0, "rst_mid");
        pulse_reset("rst_mid");
        send(4'b0101, 1, 0, 0, "rst_held");
        chk("rst_held_valid", 32'(out_valid), 1);
        pulse_reset("rst_held");
        send(4'b1110, 0, 1, 1, "after_rst");
        chk("after_rst_data", 32'(out_data), 32'h0E);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bit fs;
            fs = m_busy ? ($urandom_range(0, 19) == 0)
                        : ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), fs,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                 "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
